// File: rtl/mips_program_counter_if.sv
// Fetch-address bundle between the next-PC logic and the program counter.
// The next-PC mux drives next_address. The PC returns the fetch address
// and the values derived from it.
interface mips_program_counter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] next_address;
  logic [ADDR_WIDTH-1:0] current_address;
  logic [ADDR_WIDTH-1:0] pc_plus_4;
  logic                  misaligned;

  // next-PC / fetch side
  modport master (
    output next_address,
    input  current_address,
    input  pc_plus_4,
    input  misaligned
  );

  // program counter side
  modport slave (
    input  next_address,
    output current_address,
    output pc_plus_4,
    output misaligned
  );
endinterface

// File: rtl/mips_program_counter.sv
// Program counter for the single-clock MIPS datapath.
// It loads the externally selected next address on every rising edge.
// It also derives the sequential successor address and a word-alignment flag.
module mips_program_counter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                    INCREMENT  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_program_counter_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INCREMENT);

  logic [ADDR_WIDTH-1:0] pc;

  // PC register: reset wins over the load; otherwise load every edge (no stall)
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_ADDR;
    else       pc <= bus.next_address;
  end

  // Derived outputs depend only on the register, so they are glitch-free between edges.
  // The successor address wraps modulo 2^ADDR_WIDTH, with no carry-out.
  always_comb begin
    bus.current_address = pc;
    bus.pc_plus_4       = pc + INC;
    bus.misaligned      = |pc[1:0];
  end

endmodule

// File: tb/tb_mips_program_counter.sv
// Bench for mips_program_counter.
// It runs directed boundary cases and then random reset/load traffic.
// A one-line next-PC rule serves as the reference model.
module tb_mips_program_counter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] ref_pc;

  always #5 clk = ~clk;

  mips_program_counter_if #(.ADDR_WIDTH(32)) bus ();

  mips_program_counter #(
    .ADDR_WIDTH(32),
    .RESET_ADDR(32'h0000_0000),
    .INCREMENT (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".cur"}, bus.current_address, ref_pc);
    chk({tag, ".p4"},  bus.pc_plus_4, ref_pc + 32'd4);
    chk({tag, ".mis"}, {31'd0, bus.misaligned}, {31'd0, ref_pc[1:0] != 2'b00});
  endtask

  // Drive the inputs at the falling edge, let the rising edge happen, and update the model.
  // Check #1 after the rising edge.
  task automatic cycle(input logic r, input logic [31:0] na, input string tag);
    @(negedge clk);
    reset = r;
    bus.next_address = na;
    @(posedge clk);
    ref_pc = r ? 32'h0 : na;
    #1;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.next_address = 32'h0;

    cycle(1'b1, 32'h0, "reset");
    cycle(1'b1, 32'h1234_5678, "reset_hold");
    cycle(1'b0, 32'd31, "load31");

    // change next_address between edges: no effect until the edge
    #2 bus.next_address = 32'd8;
    #1 chk("mid_change_hold", bus.current_address, 32'd31);
    @(posedge clk);
    ref_pc = 32'd8;
    #1 chk_all("mid_change_load");

    // reset beats a simultaneous load; the next edge loads again
    cycle(1'b1, 32'd31, "reset_prio");
    cycle(1'b0, 32'd31, "after_reset");

    // reset pulse with no edge while high: nothing happens
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk("reset_glitch", bus.current_address, 32'd31);

    // wrap-around of the successor address
    cycle(1'b0, 32'hFFFF_FFFC, "wrap");
    cycle(1'b0, 32'hFFFF_FFFF, "top_misal");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] na;
      r  = ($urandom_range(0, 9) == 0);
      na = $urandom;
      case ($urandom_range(0, 3))
        0:       na[1:0] = 2'b00;
        1:       na = 32'hFFFF_FFFC - {28'd0, na[3:0]};
        default: ;
      endcase
      cycle(r, na, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
